// File: rtl/uart_rx_checked_driver_pkg.sv
// Shared definitions for the checked UART receiver: byte length, default baud
// divisor (50 MHz / 115200, also used by the transmitter), receiver state
// encodings and the 3-sample majority helper.
package uart_rx_checked_driver_pkg;

  localparam int unsigned BYTE_LEN               = 8;
  localparam int unsigned DEFAULT_CYCLES_PER_BIT = 434;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_PARITY    = 3'd3,
    UART_RX_STOP      = 3'd4,
    UART_RX_WAIT_HIGH = 3'd5
  } uart_rx_state_e;

  // Majority of three samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_checked_driver_sampler.sv
// Line front end for the UART receiver: 2-flop synchroniser on rxd, one
// extra delay flop for falling-edge detection, and a 3-sample majority vote
// taken around the bit centre.
// Ports:
//   clk, rst        - system clock, synchronous active-low reset
//   rxd             - asynchronous serial input, idle high
//   cyc             - in-bit cycle counter from the receiver FSM
//   rxd_s           - synchronised line
//   fall            - rxd_d=1 and rxd_s=0 (combinational from flops)
//   vote, vote_valid- registered majority, valid for one cycle at cyc=MID+2
module uart_rx_checked_driver_sampler
  import uart_rx_checked_driver_pkg::*;
#(
  parameter  int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  localparam int unsigned CYC_W          = $clog2(CYCLES_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [CYC_W-1:0] cyc,
  output logic             rxd_s,
  output logic             fall,
  output logic             vote,
  output logic             vote_valid
);

  localparam int unsigned MID = CYCLES_PER_BIT / 2;

  logic sync1_q;
  logic rxd_s_q;
  logic rxd_d_q;
  logic cap0_q;
  logic cap1_q;
  logic vote_q;
  logic vote_valid_q;

  // Synchroniser, delay flop and the two early captures; the third capture
  // is the live rxd_s at MID+1, folded straight into the registered vote.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_d_q      <= 1'b1;
      cap0_q       <= 1'b1;
      cap1_q       <= 1'b1;
      vote_q       <= 1'b1;
      vote_valid_q <= 1'b0;
    end else begin
      sync1_q      <= rxd;
      rxd_s_q      <= sync1_q;
      rxd_d_q      <= rxd_s_q;
      vote_valid_q <= (cyc == CYC_W'(MID + 1));
      if (cyc == CYC_W'(MID - 1)) cap0_q <= rxd_s_q;
      if (cyc == CYC_W'(MID))     cap1_q <= rxd_s_q;
      if (cyc == CYC_W'(MID + 1)) vote_q <= majority3(cap0_q, cap1_q, rxd_s_q);
    end
  end

  assign rxd_s      = rxd_s_q;
  assign fall       = rxd_d_q & ~rxd_s_q;
  assign vote       = vote_q;
  assign vote_valid = vote_valid_q;

endmodule

// File: rtl/uart_rx_checked_driver.sv
// Single-clock 8N1 UART receiver, LSB first, with start-bit validation,
// majority-voted bit sampling, stop-bit check and break detection.
// Optional even parity bit between bit 7 and stop: macro UART_RX_PARITY_EN.
// Ports:
//   clk, rst   - system clock, synchronous active-low reset
//   rxd        - asynchronous serial line, idle high
//   out        - received byte, valid while outclk=1
//   outclk     - 1-cycle strobe, good byte on out
//   frame_err  - 1-cycle strobe, stop bit sampled 0
//   break_det  - 1-cycle strobe with frame_err when all data bits are 0
//   parity_err - (UART_RX_PARITY_EN only) 1-cycle strobe, parity mismatch
module uart_rx_checked_driver
  import uart_rx_checked_driver_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT  // >= 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  output logic [BYTE_LEN-1:0] out,
  output logic                outclk,
  output logic                frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                parity_err,
`endif
  output logic                break_det
);

  localparam int unsigned CYC_W    = $clog2(CYCLES_PER_BIT);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYCLES_PER_BIT - 1);

  logic rxd_s;
  logic fall;
  logic vote;
  logic vote_valid;

  uart_rx_state_e      state_q,     state_d;
  logic [CYC_W-1:0]    cyc_q,       cyc_d;
  logic [CYC_W-1:0]    cyc_next;
  logic [2:0]          bit_idx_q,   bit_idx_d;
  logic [BYTE_LEN-1:0] shreg_q,     shreg_d;
  logic [BYTE_LEN-1:0] out_q,       out_d;
  logic                outclk_q,    outclk_d;
  logic                frame_err_q, frame_err_d;
  logic                break_det_q, break_det_d;
`ifdef UART_RX_PARITY_EN
  logic                par_bad_q,    par_bad_d;
  logic                parity_err_q, parity_err_d;
`endif

  uart_rx_checked_driver_sampler #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .cyc       (cyc_q),
    .rxd_s     (rxd_s),
    .fall      (fall),
    .vote      (vote),
    .vote_valid(vote_valid)
  );

  // Next-state and strobe logic. Bit index advances on each data vote, which
  // is equivalent to advancing at the end of each bit since exactly one vote
  // falls inside every bit.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    outclk_d    = 1'b0;
    frame_err_d = 1'b0;
    break_det_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    cyc_next = (cyc_q == LAST_CYC) ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      UART_RX_IDLE: begin
        cyc_d = '0;
        // rxd_s is one cycle into the start bit, so the counter starts at 1.
        if (fall) begin
          state_d = UART_RX_START;
          cyc_d   = CYC_W'(1);
        end
      end
      UART_RX_START: begin
        cyc_d = cyc_next;
        if (vote_valid) begin
          if (vote) begin
            state_d = UART_RX_IDLE;
            cyc_d   = '0;
          end else begin
            state_d   = UART_RX_DATA;
            bit_idx_d = '0;
          end
        end
      end
      UART_RX_DATA: begin
        cyc_d = cyc_next;
        if (vote_valid) begin
          shreg_d = {vote, shreg_q[BYTE_LEN-1:1]};
          if (bit_idx_q == 3'(BYTE_LEN - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = UART_RX_PARITY;
`else
            state_d = UART_RX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      UART_RX_PARITY: begin
        cyc_d = cyc_next;
        if (vote_valid) begin
          // Even parity: data bits plus parity bit must XOR to 0.
          par_bad_d = vote ^ (^shreg_q);
          state_d   = UART_RX_STOP;
        end
      end
`endif
      UART_RX_STOP: begin
        cyc_d = cyc_next;
        if (vote_valid) begin
          out_d = shreg_q;
          cyc_d = '0;
          if (vote) begin
            // Return to IDLE mid stop bit so an early next start is caught.
            state_d = UART_RX_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           outclk_d     = 1'b1;
`else
            outclk_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            break_det_d = (shreg_q == '0);
            state_d     = UART_RX_WAIT_HIGH;
          end
        end
      end
      UART_RX_WAIT_HIGH: begin
        cyc_d = '0;
        if (rxd_s) state_d = UART_RX_IDLE;
      end
      default: begin
        state_d = UART_RX_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= UART_RX_IDLE;
      cyc_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      out_q       <= '0;
      outclk_q    <= 1'b0;
      frame_err_q <= 1'b0;
      break_det_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      outclk_q    <= outclk_d;
      frame_err_q <= frame_err_d;
      break_det_q <= break_det_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out       = out_q;
  assign outclk    = outclk_q;
  assign frame_err = frame_err_q;
  assign break_det = break_det_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
